// File: rtl/d_sync_debounce.sv
// Input conditioner for the negative-edge D flip-flop: synchronises a raw asynchronous
// level, debounces it and emits a clean registered level plus one-cycle edge pulses.
module d_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic D,
    input  logic en,
    output logic Q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        STABLE0 = 2'd0,
        WAIT1   = 2'd1,
        STABLE1 = 2'd2,
        WAIT0   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   q_q, q_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   d_s;

    // sync_q[0] is the metastability-exposed flop; only the last stage is consumed.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], D};
    assign d_s    = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE0: begin
                if (en && d_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE1;
                        q_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = WAIT1;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT1: begin
                if (!en || !d_s) begin
                    state_d = STABLE0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE1;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE1: begin
                if (en && !d_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = STABLE0;
                        q_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = WAIT0;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            WAIT0: begin
                if (!en || d_s) begin
                    state_d = STABLE1;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE0;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE0;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= STABLE0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign Q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == WAIT0) || (state_q == WAIT1);

endmodule
